// File: rtl/flash_word_reader_pkg.sv
// Shared types and constants for the SPI-flash word reader.
package lvdc_flash_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, READY, SHIFT, GAP} state_e;

    localparam logic [7:0] READ_CMD  = 8'h03;
    localparam int         ADDR_BITS = 24;
    localparam int         CMD_BITS  = 8;
    localparam int         XFER_W    = CMD_BITS + ADDR_BITS;
endpackage

// File: rtl/flash_word_reader_if.sv
// CPU-side request/response bundle of the flash word reader.
interface flash_word_reader_if #(parameter int WORD_BITS = 16) ();
    import lvdc_flash_pkg::*;

    logic                 start;
    logic [ADDR_BITS-1:0] start_addr;
    logic                 stop;
    logic                 word_req;
    logic [WORD_BITS-1:0] word_data;
    logic                 word_valid;
    logic                 ready;
    logic                 busy;

    modport master (output start, start_addr, stop, word_req,
                    input  word_data, word_valid, ready, busy);
    modport slave  (input  start, start_addr, stop, word_req,
                    output word_data, word_valid, ready, busy);
endinterface

// File: rtl/flash_word_reader_spi_shift_engine.sv
// SPI mode-0 bit engine: SCK divider, bit-cell sequencing, MOSI drive and MISO capture.
module spi_shift_engine import lvdc_flash_pkg::*; #(
    parameter int SCK_DIV = 2,
    parameter int RX_W    = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              go_i,
    input  logic              abort_i,
    input  logic [5:0]        len_i,
    input  logic [XFER_W-1:0] tx_i,
    output logic              done_o,
    output logic [5:0]        remain_o,
    output logic [RX_W-1:0]   rx_o,
    output logic              sck_o,
    output logic              sdo_o,
    input  logic              sdi_i
);
    localparam logic [3:0] DIV_LAST = 4'(SCK_DIV - 1);

    logic              active_q, hi_q, sck_q, sdo_q;
    logic [3:0]        div_q;
    logic [5:0]        bits_q;
    logic [XFER_W-1:0] tx_q;
    logic [RX_W-1:0]   rx_q;
    logic              half_end;

    assign half_end = active_q && (div_q == DIV_LAST);
    // Asserted in the cycle whose closing edge ends the last bit cell.
    assign done_o   = half_end && hi_q && (bits_q == 6'd1);
    assign remain_o = bits_q;
    assign rx_o     = rx_q;
    assign sck_o    = sck_q;
    assign sdo_o    = sdo_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            div_q    <= '0;
            bits_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else if (abort_i) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            div_q    <= '0;
            bits_q   <= '0;
        end else if (go_i) begin
            active_q <= 1'b1;
            hi_q     <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bits_q   <= len_i;
            sdo_q    <= tx_i[XFER_W-1];
            tx_q     <= {tx_i[XFER_W-2:0], 1'b0};
        end else if (active_q) begin
            if (!half_end) begin
                div_q <= div_q + 4'd1;
            end else begin
                div_q <= '0;
                if (!hi_q) begin
                    hi_q  <= 1'b1;
                    sck_q <= 1'b1;
                    rx_q  <= {rx_q[RX_W-2:0], sdi_i};
                end else begin
                    hi_q   <= 1'b0;
                    sck_q  <= 1'b0;
                    bits_q <= bits_q - 6'd1;
                    if (bits_q == 6'd1) begin
                        active_q <= 1'b0;
                    end else begin
                        sdo_q <= tx_q[XFER_W-1];
                        tx_q  <= {tx_q[XFER_W-2:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: rtl/flash_word_reader.sv
// SPI-flash READ (0x03) sequencer streaming WORD_BITS words on demand.
// Optional FLASH_PREFETCH_EN keeps the next word shifted into a holding register.
module flash_word_reader import lvdc_flash_pkg::*; #(
    parameter int SCK_DIV   = 2,
    parameter int WORD_BITS = 16
) (
    input  logic                clk,
    input  logic                rstb,
    flash_word_reader_if.slave  bus,
    output logic                flash_csb,
    output logic                sck,
    output logic                sdo,
    input  logic                sdi
);
    localparam logic [4:0] SETUP_CLKS = 5'(SCK_DIV);
    localparam logic [4:0] GAP_CLKS   = 5'(2 * SCK_DIV);

    state_e                state_q;
    logic                  csb_q, ready_q, busy_q, valid_q, go_q, restart_q;
    logic [4:0]            cnt_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [WORD_BITS-1:0]  data_q;
`ifdef FLASH_PREFETCH_EN
    logic [WORD_BITS-1:0]  hold_q;
    logic                  pend_q;
`endif

    logic                  abort, eng_done;
    logic [5:0]            eng_len, eng_remain;
    logic [XFER_W-1:0]     eng_tx;
    logic [WORD_BITS-1:0]  eng_rx;

    assign abort   = (state_q != IDLE) && (bus.start || bus.stop);
    assign eng_tx  = (state_q == CMD) ? {READ_CMD, addr_q} : '0;
    assign eng_len = (state_q == CMD) ? 6'(XFER_W) : 6'(WORD_BITS);

    spi_shift_engine #(.SCK_DIV(SCK_DIV), .RX_W(WORD_BITS)) u_eng (
        .clk(clk), .rstb(rstb), .go_i(go_q), .abort_i(abort),
        .len_i(eng_len), .tx_i(eng_tx), .done_o(eng_done), .remain_o(eng_remain),
        .rx_o(eng_rx), .sck_o(sck), .sdo_o(sdo), .sdi_i(sdi)
    );

    assign flash_csb      = csb_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.word_valid = valid_q;
    assign bus.word_data  = data_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            csb_q     <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            go_q      <= 1'b0;
            restart_q <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef FLASH_PREFETCH_EN
            hold_q    <= '0;
            pend_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            go_q    <= 1'b0;
            if (abort) begin
                // start outranks stop: a pending restart reopens after the CS-high gap.
                state_q   <= GAP;
                csb_q     <= 1'b1;
                ready_q   <= 1'b0;
                busy_q    <= 1'b0;
                cnt_q     <= GAP_CLKS;
                restart_q <= bus.start;
                if (bus.start) addr_q <= bus.start_addr;
`ifdef FLASH_PREFETCH_EN
                pend_q    <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: if (bus.start) begin
                        state_q <= CMD;
                        csb_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= SETUP_CLKS;
                        addr_q  <= bus.start_addr;
                    end
                    CMD: begin
                        if (cnt_q != 5'd0) begin
                            cnt_q <= cnt_q - 5'd1;
                            if (cnt_q == 5'd1) go_q <= 1'b1;
                        end else if (eng_remain == 6'(ADDR_BITS)) begin
                            state_q <= ADDR;
                        end
                    end
                    ADDR: if (eng_done) begin
                        ready_q <= 1'b1;
`ifdef FLASH_PREFETCH_EN
                        state_q <= SHIFT;
                        go_q    <= 1'b1;
`else
                        state_q <= READY;
                        busy_q  <= 1'b0;
`endif
                    end
`ifdef FLASH_PREFETCH_EN
                    READY: if (bus.word_req) begin
                        data_q  <= hold_q;
                        valid_q <= 1'b1;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        go_q    <= 1'b1;
                    end
                    SHIFT: begin
                        if (bus.word_req) pend_q <= 1'b1;
                        if (eng_done) begin
                            if (pend_q || bus.word_req) begin
                                data_q  <= eng_rx;
                                valid_q <= 1'b1;
                                pend_q  <= 1'b0;
                                go_q    <= 1'b1;
                            end else begin
                                hold_q  <= eng_rx;
                                state_q <= READY;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
`else
                    READY: if (bus.word_req) begin
                        state_q <= SHIFT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        go_q    <= 1'b1;
                    end
                    SHIFT: if (eng_done) begin
                        data_q  <= eng_rx;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= READY;
                    end
`endif
                    GAP: begin
                        if (cnt_q == 5'd1) begin
                            if (restart_q) begin
                                state_q <= CMD;
                                csb_q   <= 1'b0;
                                busy_q  <= 1'b1;
                                cnt_q   <= SETUP_CLKS;
                            end else begin
                                state_q <= IDLE;
                            end
                            restart_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_flash_word_reader.sv
// Directed bench for flash_word_reader with a behavioural mode-0 SPI flash.
`timescale 1ns/1ps
module tb_flash_word_reader;
    localparam int SCK_DIV   = 2;
    localparam int WORD_BITS = 16;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic flash_csb, sck, sdo;
    logic sdi = 1'b0;

    flash_word_reader_if #(.WORD_BITS(WORD_BITS)) bus ();

    flash_word_reader #(.SCK_DIV(SCK_DIV), .WORD_BITS(WORD_BITS)) dut (
        .clk(clk), .rstb(rstb), .bus(bus),
        .flash_csb(flash_csb), .sck(sck), .sdo(sdo), .sdi(sdi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;

    always @(negedge clk) if (bus.word_valid === 1'b1) vld_cnt++;

    // Flash model: captures 32 command/address bits on SCK rise, drives data after SCK fall.
    int          fl_bits = 0;
    int          fl_dbits = 0;
    logic [31:0] fl_sr = '0;
    logic [31:0] cmd_seen = '0;
    logic [7:0]  fl_byte;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h001234: return 8'hBE;
            24'h001235: return 8'hEF;
            24'h001236: return 8'h00;
            24'h001237: return 8'h01;
            24'h000010: return 8'hCA;
            24'h000011: return 8'hFE;
            default:    return 8'hA5;
        endcase
    endfunction

    always @(posedge sck or negedge sck or posedge flash_csb) begin
        if (flash_csb !== 1'b0) begin
            fl_bits = 0; fl_dbits = 0; sdi = 1'b0;
        end else if (sck === 1'b1) begin
            if (fl_bits < 32) begin
                fl_sr = {fl_sr[30:0], sdo};
                fl_bits++;
                if (fl_bits == 32) cmd_seen = fl_sr;
            end
        end else if (fl_bits == 32) begin
            fl_byte = mem_byte(fl_sr[23:0] + 24'(fl_dbits / 8));
            sdi = fl_byte[7 - (fl_dbits % 8)];
            fl_dbits++;
        end
    end

    task automatic pulse_start(input logic [23:0] a);
        @(posedge clk); #1 bus.start = 1'b1; bus.start_addr = a;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 bus.stop = 1'b1;
        @(posedge clk); #1 bus.stop = 1'b0;
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 bus.word_req = 1'b1;
        @(posedge clk); #1 bus.word_req = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_valid(output int n, output logic [15:0] d);
        n = 0;
        while (bus.word_valid !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        d = bus.word_data;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.stop = 0; bus.word_req = 0; bus.start_addr = '0;
        #23;
        checks++; if ({flash_csb, sck, sdo} !== 3'b100) begin errors++; $display("FAIL reset_pins: got %b expected 100", {flash_csb, sck, sdo}); end
        checks++; if ({bus.word_valid, bus.ready, bus.busy} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {bus.word_valid, bus.ready, bus.busy}); end
        checks++; if (bus.word_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.word_data); end
        @(posedge clk); #1 rstb = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++; if ({flash_csb, bus.busy, bus.ready} !== 3'b100) begin errors++; $display("FAIL idle_after_reset: got %b expected 100", {flash_csb, bus.busy, bus.ready}); end
    endtask

    task automatic test_command();
        int n;
        pulse_start(24'h001234);
        checks++; if ({flash_csb, bus.busy} !== 2'b01) begin errors++; $display("FAIL cmd_open: csb/busy got %b expected 01", {flash_csb, bus.busy}); end
        wait_ready(n);
        checks++; if (n != 131) begin errors++; $display("FAIL cmd_latency: got %0d expected 131", n); end
        checks++; if (cmd_seen !== 32'h03001234) begin errors++; $display("FAIL cmd_bits: got %h expected 03001234", cmd_seen); end
`ifndef FLASH_PREFETCH_EN
        checks++; if ({bus.busy, flash_csb} !== 2'b00) begin errors++; $display("FAIL cmd_ready_state: busy/csb got %b expected 00", {bus.busy, flash_csb}); end
`endif
    endtask

    task automatic get_word(input string nm, input logic [15:0] exp);
        int n; logic [15:0] d;
        pulse_req();
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL %s_ready_drop: got %b expected 0", nm, bus.ready); end
        wait_valid(n, d);
        checks++; if (n != 65) begin errors++; $display("FAIL %s_latency: got %0d expected 65", nm, n); end
        checks++; if (d !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", nm, d, exp); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL %s_ready_rise: got %b expected 1", nm, bus.ready); end
        @(posedge clk); #1;
        checks++; if ({bus.word_valid, bus.word_data} !== {1'b0, exp}) begin errors++; $display("FAIL %s_hold: got %b/%h expected 0/%h", nm, bus.word_valid, bus.word_data, exp); end
    endtask

    task automatic test_words();
        get_word("w0", 16'hBEEF);
        get_word("w1", 16'h0001);
    endtask

    task automatic test_stop_in_shift();
        int base;
        pulse_req();
        repeat (20) @(posedge clk);
        base = vld_cnt;
        pulse_stop();
        checks++; if ({flash_csb, sck, bus.ready, bus.busy} !== 4'b1000) begin errors++; $display("FAIL stop_state: csb/sck/ready/busy got %b expected 1000", {flash_csb, sck, bus.ready, bus.busy}); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL stop_cs_high: cycle %0d got %b expected 1", k + 1, flash_csb); end
        end
        repeat (80) @(posedge clk); #1;
        checks++; if (vld_cnt != base) begin errors++; $display("FAIL stop_no_valid: got %0d pulses expected 0", vld_cnt - base); end
    endtask

    task automatic test_req_ignored();
        int n, base;
        base = vld_cnt;
        pulse_start(24'h001234);
        repeat (68) @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b expected 1", bus.busy); end
        pulse_req();
        wait_ready(n);
        checks++; if (n + 70 != 131) begin errors++; $display("FAIL ign_latency: got %0d expected 131", n + 70); end
        checks++; if (vld_cnt != base) begin errors++; $display("FAIL ign_no_valid: got %0d pulses expected 0", vld_cnt - base); end
        get_word("ign_w0", 16'hBEEF);
    endtask

    task automatic test_restart();
        int n;
        pulse_start(24'h000010);
        checks++; if ({flash_csb, sck} !== 2'b10) begin errors++; $display("FAIL rs_abort: csb/sck got %b expected 10", {flash_csb, sck}); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (flash_csb !== 1'b1) begin errors++; $display("FAIL rs_gap: cycle %0d got %b expected 1", k + 1, flash_csb); end
        end
        @(posedge clk); #1;
        checks++; if (flash_csb !== 1'b0) begin errors++; $display("FAIL rs_reopen: got %b expected 0", flash_csb); end
        wait_ready(n);
        checks++; if (n + 4 != 135) begin errors++; $display("FAIL rs_latency: got %0d expected 135", n + 4); end
        checks++; if (cmd_seen !== 32'h03000010) begin errors++; $display("FAIL rs_cmd_bits: got %h expected 03000010", cmd_seen); end
        get_word("rs_w0", 16'hCAFE);
    endtask

    task automatic test_req_and_stop();
        int base;
        base = vld_cnt;
        @(posedge clk); #1 bus.word_req = 1'b1; bus.stop = 1'b1;
        @(posedge clk); #1 bus.word_req = 1'b0; bus.stop = 1'b0;
        checks++; if ({flash_csb, bus.ready, bus.busy} !== 3'b100) begin errors++; $display("FAIL rqstop_state: got %b expected 100", {flash_csb, bus.ready, bus.busy}); end
        repeat (80) @(posedge clk); #1;
        checks++; if (vld_cnt != base) begin errors++; $display("FAIL rqstop_no_valid: got %0d pulses expected 0", vld_cnt - base); end
    endtask

`ifdef FLASH_PREFETCH_EN
    task automatic test_prefetch();
        int n; logic [15:0] d;
        pulse_req();
        wait_valid(n, d);
        checks++; if (d !== 16'hBEEF || n >= 1000) begin errors++; $display("FAIL pf_w0: got %h after %0d expected BEEF", d, n); end
        repeat (80) @(posedge clk);
        pulse_req();
        checks++; if ({bus.word_valid, bus.word_data} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL pf_w1_fast: got %b/%h expected 1/0001", bus.word_valid, bus.word_data); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL pf_ready: got %b expected 1", bus.ready); end
    endtask
`endif

    task automatic test_async_reset();
        pulse_start(24'h001234);
        repeat (60) @(posedge clk); #3;
        checks++; if (flash_csb !== 1'b0) begin errors++; $display("FAIL ar_pre: csb got %b expected 0", flash_csb); end
        rstb = 1'b0;
        #1;
        checks++; if ({flash_csb, sck, sdo} !== 3'b100) begin errors++; $display("FAIL ar_pins: got %b expected 100", {flash_csb, sck, sdo}); end
        checks++; if ({bus.word_valid, bus.ready, bus.busy} !== 3'b000 || bus.word_data !== 16'h0000) begin errors++; $display("FAIL ar_status: got %b/%h expected 000/0000", {bus.word_valid, bus.ready, bus.busy}, bus.word_data); end
        #10 rstb = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_command();
`ifdef FLASH_PREFETCH_EN
        test_prefetch();
`else
        test_words();
        test_stop_in_shift();
        test_req_ignored();
        test_restart();
        test_req_and_stop();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
